// File: rtl/isfifoctl_sp2x.sv
// isfifoctl_sp2x: stream FIFO controller around a single-port RAM with
// two-cycle read latency. Writes and prefetch reads share the RAM port under
// a last-grant alternation; returning read data lands in a 3-entry output
// buffer whose credits (obuf + in-flight) cap outstanding reads at 3.
module isfifoctl_sp2x #(
    parameter int ADDRBIT = 11,
    parameter int DEPTH   = 1536,
    parameter int WIDTH   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_vld,
    input  logic [WIDTH-1:0]   wr_dat,
    output logic               wr_rdy,
    output logic               rd_vld,
    output logic [WIDTH-1:0]   rd_dat,
    input  logic               rd_rdy,
    output logic [ADDRBIT-1:0] ram_a,
    output logic               ram_we,
    output logic               ram_re,
    output logic [WIDTH-1:0]   ram_di,
    input  logic [WIDTH-1:0]   ram_do,
    output logic [ADDRBIT+1:0] count,
    output logic               full,
    output logic               empty
);

    localparam int CW = ADDRBIT + 1;
    localparam logic [ADDRBIT-1:0] LAST_A  = ADDRBIT'(DEPTH - 1);
    localparam logic [CW-1:0]      DEPTH_C = CW'(DEPTH);

    logic [ADDRBIT-1:0] wptr, rptr, ram_a_q;
    logic [CW-1:0]      ram_cnt;
    logic [1:0]         inf;
    logic [1:0]         inf_cnt;
    logic [1:0]         obuf_cnt;
    logic [1:0]         cnt_after_pop;
    logic [WIDTH-1:0]   obuf     [3];
    logic [WIDTH-1:0]   obuf_nxt [3];
    logic               lg;
    logic               rd_elig, wr_elig, rd_gnt, wr_gnt, pop, push;

    // Pointers wrap at DEPTH, which need not be a power of two.
    function automatic logic [ADDRBIT-1:0] ptr_inc(input logic [ADDRBIT-1:0] p);
        return (p == LAST_A) ? '0 : p + ADDRBIT'(1);
    endfunction

    assign inf_cnt = {1'b0, inf[0]} + {1'b0, inf[1]};
    // A pop in the same cycle is not credited, keeping the buffer overflow-free.
    assign rd_elig = (ram_cnt != '0) && (({1'b0, obuf_cnt} + {1'b0, inf_cnt}) < 3'd3);
    assign wr_elig = wr_vld && (ram_cnt < DEPTH_C);

    // Single-port arbitration: on contention grant the side that did not win last.
    always_comb begin
        rd_gnt = 1'b0;
        wr_gnt = 1'b0;
        if (!rst) begin
            if (rd_elig && wr_elig) begin
                rd_gnt = ~lg;
                wr_gnt = lg;
            end else begin
                rd_gnt = rd_elig;
                wr_gnt = wr_elig;
            end
        end
    end

    assign wr_rdy = ~rst & (ram_cnt < DEPTH_C) & ~rd_gnt;
    assign ram_we = wr_gnt;
    assign ram_re = rd_gnt;
    assign ram_a  = wr_gnt ? wptr : (rd_gnt ? rptr : ram_a_q);
    assign ram_di = rst ? '0 : wr_dat;

    assign rd_vld = (obuf_cnt != 2'd0);
    assign rd_dat = obuf[0];
    assign pop    = rd_vld & rd_rdy;
    assign push   = inf[1];

    assign count = {1'b0, ram_cnt} + {{ADDRBIT{1'b0}}, inf_cnt} + {{ADDRBIT{1'b0}}, obuf_cnt};
    assign full  = (ram_cnt == DEPTH_C);
    assign empty = (count == '0);

    // Output buffer next contents: shift out the head on pop, then append the RAM word.
    always_comb begin
        obuf_nxt      = obuf;
        cnt_after_pop = obuf_cnt - {1'b0, pop};
        if (pop) begin
            obuf_nxt[0] = obuf[1];
            obuf_nxt[1] = obuf[2];
        end
        if (push) begin
            for (int i = 0; i < 3; i++) begin
                if (cnt_after_pop == 2'(i)) obuf_nxt[i] = ram_do;
            end
        end
    end

    // RAM pointers, occupancy and last-grant bookkeeping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr    <= '0;
            rptr    <= '0;
            ram_cnt <= '0;
            lg      <= 1'b0;
        end else begin
            if (wr_gnt) begin
                wptr    <= ptr_inc(wptr);
                ram_cnt <= ram_cnt + CW'(1);
                lg      <= 1'b0;
            end else if (rd_gnt) begin
                rptr    <= ptr_inc(rptr);
                ram_cnt <= ram_cnt - CW'(1);
                lg      <= 1'b1;
            end
        end
    end

    // In-flight read tracker mirroring the RAM's two-cycle read pipeline.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) inf <= 2'b00;
        else     inf <= {inf[0], rd_gnt};
    end

    // Output buffer storage and fill level.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 3; i++) obuf[i] <= '0;
            obuf_cnt <= 2'd0;
        end else begin
            obuf     <= obuf_nxt;
            obuf_cnt <= obuf_cnt + {1'b0, push} - {1'b0, pop};
        end
    end

    // Remember the last driven address so idle cycles keep ram_a stable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) ram_a_q <= '0;
        else     ram_a_q <= ram_a;
    end

endmodule

// File: tb/tb_isfifoctl_sp2x.sv
// Bench for isfifoctl_sp2x: RAM model with two-cycle read latency, a queue
// scoreboard fed on write acceptance and drained by a negedge monitor, plus
// directed latency/full/reset checks and randomized traffic.
module tb_isfifoctl_sp2x;

    localparam int ADDRBIT = 11;
    localparam int DEPTH   = 1536;
    localparam int WIDTH   = 32;

    logic               clk = 1'b0;
    logic               rst;
    logic               wr_vld;
    logic [WIDTH-1:0]   wr_dat;
    logic               wr_rdy;
    logic               rd_vld;
    logic [WIDTH-1:0]   rd_dat;
    logic               rd_rdy;
    logic [ADDRBIT-1:0] ram_a;
    logic               ram_we;
    logic               ram_re;
    logic [WIDTH-1:0]   ram_di;
    logic [WIDTH-1:0]   ram_do;
    logic [ADDRBIT+1:0] count;
    logic               full;
    logic               empty;

    isfifoctl_sp2x #(.ADDRBIT(ADDRBIT), .DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .wr_vld(wr_vld), .wr_dat(wr_dat), .wr_rdy(wr_rdy),
        .rd_vld(rd_vld), .rd_dat(rd_dat), .rd_rdy(rd_rdy),
        .ram_a(ram_a), .ram_we(ram_we), .ram_re(ram_re),
        .ram_di(ram_di), .ram_do(ram_do),
        .count(count), .full(full), .empty(empty)
    );

    always #5 clk = ~clk;

    // Single-port RAM: read cycle then registered output; not reset, like silicon.
    logic [WIDTH-1:0] mem [2**ADDRBIT];
    logic [WIDTH-1:0] q1, q2;
    always @(posedge clk) begin
        if (ram_we) mem[ram_a] <= ram_di;
        if (ram_re) q1 <= mem[ram_a];
        q2 <= q1;
    end
    assign ram_do = q2;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // Reference model: FIFO contents, words held, and linear write/read counts.
    logic [WIDTH-1:0]   sb [$];
    int                 held = 0;
    int                 wa = 0;
    int                 ra = 0;
    logic [ADDRBIT-1:0] last_a = '0;

    initial forever begin
        @(negedge clk);
        if (rst) begin
            sb.delete();
            held   = 0;
            wa     = 0;
            ra     = 0;
            last_a = '0;
        end else begin
            chk("count", count, held);
            chk("empty", empty, held == 0);
            chk("count_bound", count <= DEPTH + 3, 1'b1);
            if (full) chk("wr_rdy_when_full", wr_rdy, 1'b0);
            chk("we_re_exclusive", ram_we & ram_re, 1'b0);
            chk("we_is_handshake", ram_we, wr_vld & wr_rdy);
            if (ram_we) begin
                chk("wr_addr", ram_a, wa % DEPTH);
                chk("ram_di", ram_di, wr_dat);
                wa++;
            end
            if (ram_re) begin
                chk("rd_addr", ram_a, ra % DEPTH);
                ra++;
            end
            if (!ram_we && !ram_re) chk("ram_a_hold", ram_a, last_a);
            last_a = ram_a;
            if (wr_vld && wr_rdy) begin
                sb.push_back(wr_dat);
                held++;
            end
            if (rd_vld && rd_rdy) begin
                if (sb.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL unexpected_output: actual=%0h required=none", rd_dat);
                end else begin
                    chk("rd_dat", rd_dat, sb.pop_front());
                end
                held--;
            end
        end
    end

    logic [WIDTH-1:0] dnext;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_cycle(input bit v, input bit r);
        tick();
        wr_vld = v;
        wr_dat = dnext;
        rd_rdy = r;
        @(negedge clk);
        if (v && wr_rdy) dnext++;
    endtask

    task automatic chk_reset_outputs();
        chk("rst_wr_rdy", wr_rdy, 1'b0);
        chk("rst_rd_vld", rd_vld, 1'b0);
        chk("rst_rd_dat", rd_dat, '0);
        chk("rst_ram_we", ram_we, 1'b0);
        chk("rst_ram_re", ram_re, 1'b0);
        chk("rst_ram_a", ram_a, '0);
        chk("rst_ram_di", ram_di, '0);
        chk("rst_count", count, '0);
        chk("rst_full", full, 1'b0);
        chk("rst_empty", empty, 1'b1);
    endtask

    task automatic reset_pulse();
        tick();
        rst    = 1'b1;
        wr_vld = 1'b1;
        wr_dat = 32'hFFFF_0000;
        rd_rdy = 1'b0;
        @(negedge clk);
        chk_reset_outputs();
        tick();
        rst    = 1'b0;
        wr_vld = 1'b0;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        do begin
            send_cycle(1'b0, 1'b1);
            n++;
        end while ((count != 0 || rd_vld) && n < budget);
        chk("drain_count", count, '0);
        chk("drain_sb_empty", sb.size(), 0);
    endtask

    initial begin
        logic [WIDTH-1:0] n0;
        int               n;

        rst    = 1'b1;
        wr_vld = 1'b1;
        wr_dat = 32'h1234_5678;
        rd_rdy = 1'b1;
        dnext  = 32'h0000_1000;
        repeat (3) @(negedge clk);
        chk_reset_outputs();
        tick();
        rst    = 1'b0;
        wr_vld = 1'b0;
        @(negedge clk);

        // Fall-through latency of a single word.
        tick();
        wr_vld = 1'b1;
        wr_dat = 32'hA5A5_0001;
        rd_rdy = 1'b1;
        @(negedge clk);
        chk("ft_we", ram_we, 1'b1);
        chk("ft_we_addr", ram_a, '0);
        chk("ft_wr_rdy", wr_rdy, 1'b1);
        tick();
        wr_vld = 1'b0;
        @(negedge clk);
        chk("ft_re", ram_re, 1'b1);
        chk("ft_re_addr", ram_a, '0);
        tick(); @(negedge clk);
        chk("ft_vld_n2", rd_vld, 1'b0);
        tick(); @(negedge clk);
        chk("ft_vld_n3", rd_vld, 1'b0);
        tick(); @(negedge clk);
        chk("ft_vld_n4", rd_vld, 1'b1);
        chk("ft_dat_n4", rd_dat, 32'hA5A5_0001);
        tick(); @(negedge clk);
        chk("ft_count_n5", count, '0);
        chk("ft_empty_n5", empty, 1'b1);

        // Fill with the consumer stalled: RAM full plus three buffered words.
        n0 = dnext;
        for (int i = 0; i < DEPTH + 40; i++) send_cycle(1'b1, 1'b0);
        chk("fill_accepted", dnext - n0, DEPTH + 3);
        chk("fill_full", full, 1'b1);
        chk("fill_wr_rdy", wr_rdy, 1'b0);
        chk("fill_count", count, DEPTH + 3);
        chk("fill_rd_vld", rd_vld, 1'b1);
        chk("fill_head", rd_dat, n0);
        drain(3 * DEPTH);

        // Continuous write and read traffic.
        n0 = dnext;
        for (int i = 0; i < 200; i++) send_cycle(1'b1, 1'b1);
        chk("cont_write_rate", (dnext - n0) >= 99, 1'b1);
        drain(50);

        // Randomized traffic through several pointer wraps.
        n0 = dnext;
        n  = 0;
        while ((dnext - n0) < 4000 && n < 40000) begin
            send_cycle($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
            n++;
        end
        chk("rand_written", dnext - n0, 4000);
        drain(3 * DEPTH + 100);

        // Reset with reads in flight and data buffered.
        n = 0;
        do begin
            send_cycle(1'b1, 1'b0);
            n++;
        end while (!(ram_re && rd_vld) && n < 40);
        chk("rst_setup_reached", ram_re && rd_vld, 1'b1);
        reset_pulse();
        for (int i = 0; i < 6; i++) begin
            send_cycle(1'b0, 1'b1);
            chk("post_rst_rd_vld", rd_vld, 1'b0);
        end
        dnext = 32'hDEAD_BEEF;
        send_cycle(1'b1, 1'b1);
        chk("post_rst_first_addr", ram_a, '0);
        drain(20);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: actual=timeout required=finish");
        $fatal(1, "simulation time limit reached");
    end

endmodule
